lsu_axi_master: RTL and testbench

//  Load/store unit with a full AXI4 master handshake: accepts one load/store request from the

---
 rtl/lsu_axi_master_pkg.sv | 50 +++++
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/lsu_axi_master.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_axi_master_pkg.sv
// Shared types for the load/store unit: op codes, FSM states, AXI constants, MMIO defaults.
// Pure declarations; no latency or backpressure of its own.
// Op helpers classify a request as load/store and give its AXI transfer size.
package lsu_axi_master_pkg;

  typedef enum logic [3:0] {
    LSU_OP_NOP = 4'h0,
    LSU_OP_LB  = 4'h1,
    LSU_OP_LBU = 4'h2,
    LSU_OP_LH  = 4'h3,
    LSU_OP_LHU = 4'h4,
    LSU_OP_LW  = 4'h5,
    LSU_OP_SB  = 4'h6,
    LSU_OP_SH  = 4'h7,
    LSU_OP_SW  = 4'h8
  } lsu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_WR,
    ST_B,
    ST_RESP
  } lsu_state_e;

  localparam int          AXI_ID_W       = 4;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [31:0] LSU_MMIO_BASE  = 32'h1000_0000;
  localparam logic [31:0] LSU_MMIO_LIMIT = 32'h1000_00f0;

  function automatic logic is_load(lsu_op_e op);
    return op inside {LSU_OP_LB, LSU_OP_LBU, LSU_OP_LH, LSU_OP_LHU, LSU_OP_LW};
  endfunction

  function automatic logic is_store(lsu_op_e op);
    return op inside {LSU_OP_SB, LSU_OP_SH, LSU_OP_SW};
  endfunction

  // AXI size encoding: 0 byte, 1 half, 2 word
  function automatic logic [2:0] op_size(lsu_op_e op);
    case (op)
      LSU_OP_LH, LSU_OP_LHU, LSU_OP_SH: return 3'd1;
      LSU_OP_LW, LSU_OP_SW:             return 3'd2;
      default:                          return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the core and the AXI data bus: store shift/strobe, load extract/extend.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module lsu_lane_align
  import lsu_axi_master_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int BUS_W  = 64,
  localparam int NB     = BUS_W / 8,
  localparam int LANE_W = $clog2(NB)
) (
  input  lsu_op_e           op,
  input  logic [LANE_W-1:0] lane,
  input  logic [XLEN-1:0]   st_data,
  input  logic [BUS_W-1:0]  rdata,
  output logic [BUS_W-1:0]  wdata,
  output logic [NB-1:0]     wstrb,
  output logic [XLEN-1:0]   ld_data
);

  logic [BUS_W-1:0] st_ext;
  logic [NB-1:0]    strb_base;
  logic [2:0]       size;
  logic [31:0]      rword;

  always_comb begin
    size       = op_size(op);
    st_ext     = '0;
    strb_base  = '0;
    st_ext[7:0]  = st_data[7:0];
    strb_base[0] = 1'b1;
    if (size != 3'd0) begin
      st_ext[15:8] = st_data[15:8];
      strb_base[1] = 1'b1;
    end
    if (size == 3'd2) begin
      st_ext[31:16]  = st_data[31:16];
      strb_base[3:2] = 2'b11;
    end
    wdata = st_ext << {lane, 3'b000};
    wstrb = strb_base << lane;
  end

  // The addressed bytes always land in the low word after shifting down by the lane
  always_comb begin
    rword = 32'(rdata >> {lane, 3'b000});
    case (op)
      LSU_OP_LB:  ld_data = {{(XLEN-8){rword[7]}}, rword[7:0]};
      LSU_OP_LBU: ld_data = {{(XLEN-8){1'b0}}, rword[7:0]};
      LSU_OP_LH:  ld_data = {{(XLEN-16){rword[15]}}, rword[15:0]};
      LSU_OP_LHU: ld_data = {{(XLEN-16){1'b0}}, rword[15:0]};
      LSU_OP_LW:  ld_data = XLEN'(rword);
      default:    ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Load/store unit issuing one single-beat AXI4 read or write per request; LSU_BUS_ERR_EN maps rresp/bresp to fault[1].
// Latency: 3 cycles accept->resp with a zero-wait bus; misaligned and no-op requests respond after 1.
// Backpressure: req_ready_o only in IDLE; AXI valids hold until ready; resp pulse cannot be stalled.
module lsu_axi_master
  import lsu_axi_master_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter int               ADDR_W     = 32,
  parameter int               BUS_W      = 64,
  parameter logic [ADDR_W-1:0] MMIO_BASE  = ADDR_W'(LSU_MMIO_BASE),
  parameter logic [ADDR_W-1:0] MMIO_LIMIT = ADDR_W'(LSU_MMIO_LIMIT),
  parameter int               AXI_ID     = 0,
  localparam int              NB         = BUS_W / 8,
  localparam int              LANE_W     = $clog2(NB)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [3:0]          req_op_i,
  input  logic [XLEN-1:0]     base_i,
  input  logic [XLEN-1:0]     imm_i,
  input  logic [XLEN-1:0]     st_data_i,
  output logic                resp_valid_o,
  output logic [XLEN-1:0]     resp_data_o,
  output logic [1:0]          resp_fault_o,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [AXI_ID_W-1:0] awid,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [BUS_W-1:0]    wdata,
  output logic [NB-1:0]       wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [AXI_ID_W-1:0] arid,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [BUS_W-1:0]    rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(NB - 1);

  lsu_state_e        state;
  lsu_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   st_q;

  lsu_op_e           req_op;
  logic [ADDR_W-1:0] addr_sum;
  logic [2:0]        req_size;
  logic              req_misaligned;
  logic [ADDR_W-1:0] ax_addr;
  logic [XLEN-1:0]   ld_data;
  logic              rd_err;
  logic              wr_err;

  assign req_op   = lsu_op_e'(req_op_i);
  assign addr_sum = ADDR_W'(base_i) + ADDR_W'(imm_i);
  assign req_size = op_size(req_op);
  assign req_misaligned = ((req_size == 3'd1) && addr_sum[0]) ||
                          ((req_size == 3'd2) && (addr_sum[1:0] != 2'b00));

  // MMIO devices see the exact byte address; memory sees bus-aligned beats
  assign ax_addr = ((addr_q >= MMIO_BASE) && (addr_q < MMIO_LIMIT)) ? addr_q : (addr_q & ALIGN_MASK);

  assign araddr  = ax_addr;
  assign awaddr  = ax_addr;
  assign arsize  = op_size(op_q);
  assign awsize  = op_size(op_q);
  assign arlen   = 8'd0;
  assign awlen   = 8'd0;
  assign arburst = AXI_BURST_INCR;
  assign awburst = AXI_BURST_INCR;
  assign arid    = AXI_ID_W'(AXI_ID);
  assign awid    = AXI_ID_W'(AXI_ID);
  assign wlast   = 1'b1;

  lsu_lane_align #(
    .XLEN  (XLEN),
    .BUS_W (BUS_W)
  ) u_lane_align (
    .op      (op_q),
    .lane    (addr_q[LANE_W-1:0]),
    .st_data (st_q),
    .rdata   (rdata),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .ld_data (ld_data)
  );

`ifdef LSU_BUS_ERR_EN
  assign rd_err = (rresp != AXI_RESP_OKAY);
  assign wr_err = (bresp != AXI_RESP_OKAY);
  logic unused_inputs;
  assign unused_inputs = rlast;
`else
  assign rd_err = 1'b0;
  assign wr_err = 1'b0;
  logic unused_inputs;
  assign unused_inputs = ^{rlast, rresp, bresp};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      op_q         <= LSU_OP_NOP;
      addr_q       <= '0;
      st_q         <= '0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_fault_o <= 2'b00;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      awvalid      <= 1'b0;
      wvalid       <= 1'b0;
      bready       <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_q        <= req_op;
            addr_q      <= addr_sum;
            st_q        <= st_data_i;
            req_ready_o <= 1'b0;
            if (!is_load(req_op) && !is_store(req_op)) begin
              state        <= ST_RESP;
              resp_valid_o <= 1'b1;
              resp_data_o  <= '0;
              resp_fault_o <= 2'b00;
            end else if (req_misaligned) begin
              state        <= ST_RESP;
              resp_valid_o <= 1'b1;
              resp_data_o  <= '0;
              resp_fault_o <= 2'b01;
            end else if (is_load(req_op)) begin
              state   <= ST_AR;
              arvalid <= 1'b1;
            end else begin
              state   <= ST_WR;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            rready       <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_data_o  <= rd_err ? '0 : ld_data;
            resp_fault_o <= {rd_err, 1'b0};
            state        <= ST_RESP;
          end
        end
        ST_WR: begin
          // Address and data channels complete independently, in any order
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= ST_B;
          end
        end
        ST_B: begin
          if (bvalid) begin
            bready       <= 1'b0;
            resp_valid_o <= 1'b1;
            resp_data_o  <= '0;
            resp_fault_o <= {wr_err, 1'b0};
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          req_ready_o <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          req_ready_o <= 1'b1;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master with a reactive single-beat AXI slave.
module tb_lsu_axi_master;
  import lsu_axi_master_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] base_v = '0;
  logic [31:0] imm_v = '0;
  logic [31:0] st_data = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [1:0]  resp_fault;
  logic        awvalid, awready = 1'b0;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready = 1'b0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid = 1'b0, bready;
  logic [1:0]  bresp = 2'b00;
  logic        arvalid, arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid = 1'b0, rready;
  logic [63:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b0;

  lsu_axi_master dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .base_i(base_v), .imm_i(imm_v), .st_data_i(st_data),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_fault_o(resp_fault),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // First-beat snapshot of the address/data channels and the response seen
  logic [31:0] c_addr;
  logic [2:0]  c_size;
  logic [7:0]  c_len;
  logic [1:0]  c_burst;
  logic [3:0]  c_id;
  logic [63:0] c_wdata;
  logic [7:0]  c_wstrb;
  logic        c_wlast;
  logic [31:0] r_data;
  logic [1:0]  r_fault;
  int resp_k, n_resp, a_hi, w_hi, stab_err;

  task automatic issue(input logic [3:0] op, input logic [31:0] base, input logic [31:0] imm,
                       input logic [31:0] sd);
    req_valid = 1'b1;
    req_op    = op;
    base_v    = base;
    imm_v     = imm;
    st_data   = sd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  // Slave: raises a ready once its valid has been seen for a_dly / w_dly cycles; R/B answer at once
  task automatic drive_bus(input int a_dly, input int w_dly, input logic [63:0] rd, input logic [1:0] rsp);
    bit captured;
    captured = 1'b0;
    resp_k = -1; n_resp = 0; a_hi = 0; w_hi = 0; stab_err = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if ((arvalid || awvalid) && !captured) begin
        captured = 1'b1;
        c_addr  = arvalid ? araddr  : awaddr;
        c_size  = arvalid ? arsize  : awsize;
        c_len   = arvalid ? arlen   : awlen;
        c_burst = arvalid ? arburst : awburst;
        c_id    = arvalid ? arid    : awid;
        c_wdata = wdata;
        c_wstrb = wstrb;
        c_wlast = wlast;
      end
      if (awvalid && (awaddr !== c_addr)) stab_err++;
      if (arvalid && (araddr !== c_addr)) stab_err++;
      if (wvalid && ((wdata !== c_wdata) || (wstrb !== c_wstrb))) stab_err++;
      arready = arvalid && (a_hi + 1 >= a_dly);
      awready = awvalid && (a_hi + 1 >= a_dly);
      wready  = wvalid && (w_hi + 1 >= w_dly);
      if (arvalid || awvalid) a_hi++;
      if (wvalid) w_hi++;
      rvalid = rready; rdata = rd; rresp = rsp; rlast = 1'b1;
      bvalid = bready; bresp = rsp;
      if (resp_valid) begin
        n_resp++;
        if (resp_k < 0) begin
          resp_k  = k;
          r_data  = resp_data;
          r_fault = resp_fault;
        end
      end else if (resp_k >= 0) begin
        break;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready, resp_valid}), 64'h0);
    chk("rst_resp_data", 64'(resp_data), 64'h0);
    chk("rst_resp_fault", 64'(resp_fault), 64'h0);
    reset = 1'b0;
    @(negedge clock);

    // SW to lane 4 of a 64-bit beat
    issue(LSU_OP_SW, 32'h8000_0000, 32'h4, 32'hDEAD_BEEF);
    drive_bus(1, 1, 64'h0, 2'b00);
    chk("sw_awaddr", 64'(c_addr), 64'h8000_0000);
    chk("sw_wstrb", 64'(c_wstrb), 64'hF0);
    chk("sw_wdata", c_wdata, 64'hDEAD_BEEF_0000_0000);
    chk("sw_size", 64'(c_size), 64'h2);
    chk("sw_len_burst_id_last", 64'({c_len, c_burst, c_id, c_wlast}), 64'({8'h0, 2'b01, 4'h0, 1'b1}));
    chk("sw_latency", 64'(resp_k), 64'd2);
    chk("sw_pulses", 64'(n_resp), 64'd1);
    chk("sw_resp", 64'({r_fault, r_data}), 64'h0);
    chk("sw_stable", 64'(stab_err), 64'd0);

    // LB / LBU on the top byte
    issue(LSU_OP_LB, 32'h8000_0007, 32'h0, 32'h0);
    drive_bus(1, 1, 64'h8011_2233_4455_6677, 2'b00);
    chk("lb_araddr", 64'(c_addr), 64'h8000_0000);
    chk("lb_size", 64'(c_size), 64'h0);
    chk("lb_data", 64'(r_data), 64'hFFFF_FF80);
    chk("lb_latency", 64'(resp_k), 64'd2);
    issue(LSU_OP_LBU, 32'h8000_0007, 32'h0, 32'h0);
    drive_bus(1, 1, 64'h8011_2233_4455_6677, 2'b00);
    chk("lbu_data", 64'(r_data), 64'h0000_0080);

    // No-op code: immediate response, zero data, no bus access
    issue(4'hF, 32'h8000_0000, 32'h0, 32'h0);
    drive_bus(1, 1, 64'h0, 2'b00);
    chk("nop_latency", 64'(resp_k), 64'd0);
    chk("nop_no_bus", 64'(a_hi), 64'd0);
    chk("nop_resp", 64'({r_fault, r_data}), 64'h0);

    // Halfword loads at lane 2
    issue(LSU_OP_LHU, 32'h8000_0000, 32'h2, 32'h0);
    drive_bus(1, 1, 64'h0123_4567_89AB_CDEF, 2'b00);
    chk("lhu_data", 64'(r_data), 64'h0000_89AB);
    chk("lhu_size", 64'(c_size), 64'h1);
    issue(LSU_OP_LH, 32'h8000_0000, 32'h2, 32'h0);
    drive_bus(1, 1, 64'h0123_4567_89AB_CDEF, 2'b00);
    chk("lh_data", 64'(r_data), 64'hFFFF_89AB);

    // SB inside the MMIO window keeps the byte address
    issue(LSU_OP_SB, 32'h1000_0000, 32'h3, 32'h1234_56AB);
    drive_bus(1, 1, 64'h0, 2'b00);
    chk("sb_mmio_awaddr", 64'(c_addr), 64'h1000_0003);
    chk("sb_wstrb", 64'(c_wstrb), 64'h08);
    chk("sb_wdata", c_wdata, 64'h0000_0000_AB00_0000);

    // SH at lane 6
    issue(LSU_OP_SH, 32'h8000_0000, 32'h6, 32'h1234_5678);
    drive_bus(1, 1, 64'h0, 2'b00);
    chk("sh_wstrb", 64'(c_wstrb), 64'hC0);
    chk("sh_wdata", c_wdata, 64'h5678_0000_0000_0000);

    // Misaligned LH
    issue(LSU_OP_LH, 32'h8000_0001, 32'h0, 32'h0);
    drive_bus(1, 1, 64'h0, 2'b00);
    chk("mis_latency", 64'(resp_k), 64'd0);
    chk("mis_no_bus", 64'(a_hi), 64'd0);
    chk("mis_fault", 64'(r_fault), 64'h1);
    chk("mis_data", 64'(r_data), 64'h0);

    // awready three cycles late, wready immediate
    issue(LSU_OP_SW, 32'h8000_0010, 32'h0, 32'h0BAD_F00D);
    drive_bus(3, 1, 64'h0, 2'b00);
    chk("dly_aw_cycles", 64'(a_hi), 64'd3);
    chk("dly_w_cycles", 64'(w_hi), 64'd1);
    chk("dly_latency", 64'(resp_k), 64'd4);
    chk("dly_pulses", 64'(n_resp), 64'd1);
    chk("dly_stable", 64'(stab_err), 64'd0);

    // LW with wrapping address arithmetic and an SLVERR response
    issue(LSU_OP_LW, 32'h8000_0010, 32'hFFFF_FFFC, 32'h0);
    drive_bus(1, 1, 64'hCAFE_F00D_1122_3344, 2'b10);
    chk("lw_araddr", 64'(c_addr), 64'h8000_0008);
`ifdef LSU_BUS_ERR_EN
    chk("lw_err_fault", 64'(r_fault), 64'h2);
    chk("lw_err_data", 64'(r_data), 64'h0);
`else
    chk("lw_err_fault", 64'(r_fault), 64'h0);
    chk("lw_err_data", 64'(r_data), 64'hCAFE_F00D);
`endif

    // Reset while waiting for B
    issue(LSU_OP_SW, 32'h8000_0000, 32'h0, 32'h1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      awready = awvalid;
      wready  = wvalid;
      if (bready) break;
    end
    chk("rb_reached_b", 64'(bready), 64'h1);
    reset = 1'b1;
    awready = 1'b0;
    wready  = 1'b0;
    @(negedge clock);
    chk("rb_req_ready", 64'(req_ready), 64'h1);
    chk("rb_valids", 64'({arvalid, awvalid, wvalid, rready, bready, resp_valid}), 64'h0);
    reset = 1'b0;
    @(negedge clock);

    issue(LSU_OP_LBU, 32'h8000_0005, 32'h0, 32'h0);
    drive_bus(1, 1, 64'h0000_5A00_0000_0000, 2'b00);
    chk("recover_lbu", 64'(r_data), 64'h0000_005A);
    chk("recover_pulses", 64'(n_resp), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
